// File: rtl/spart_pkg.sv
// Shared constants for the SPART bus responder: register map, status bit layout and the
// divisor loaded at reset.
package spart_pkg;

    localparam int unsigned SPART_DIV_W = 16;
    // 9600 baud from a 50 MHz clock
    localparam logic [15:0] DEF_DIVISOR = 16'h1458;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int unsigned STAT_RDA   = 0;
    localparam int unsigned STAT_TBR   = 1;
    localparam int unsigned STAT_RXOVR = 2;
    localparam int unsigned STAT_TXOVR = 3;

endpackage

// File: rtl/spart_baud_gen.sv
// Bit-rate tick generator: a down-counter that reloads from the divisor and pulses baud_tick
// once per divisor clocks.
module spart_baud_gen #(
    parameter int unsigned      DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEF_DIVISOR = 16'h1458
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] divisor,
    input  logic             reload,
    output logic             baud_tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        baud_tick = 1'b0;
        if (reload) begin
            cnt_d = divisor;
        end else if (divisor != '0) begin
            // A zero count (left over from a zero divisor) reloads without ticking
            if (cnt_q <= DIV_W'(1)) begin
                cnt_d     = divisor;
                baud_tick = (cnt_q == DIV_W'(1));
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= DEF_DIVISOR;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spart_bus_responder.sv
// Processor-facing side of the SPART: register file behind the iocs/iorw/ioaddr bus, TX/RX
// byte handshakes with the shift engines and the baud tick source.
module spart_bus_responder #(
    parameter int unsigned      DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEF_DIVISOR = 16'h1458
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       baud_tick,
    output logic       tx_load,
    output logic [7:0] tx_byte,
    input  logic       tx_busy,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte
);

    import spart_pkg::*;

    logic             rd_en, wr_en, buf_rd, stat_rd, buf_wr, dbl_wr, dbh_wr;
    logic [7:0]       rx_buf_q, rx_buf_d, tx_hold_q, tx_hold_d;
    logic             rda_q, rda_d, tbr_q, tbr_d;
    logic             rx_ovr_q, rx_ovr_d, tx_ovr_q, tx_ovr_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       status, rdata;

    assign rd_en   = iocs & iorw;
    assign wr_en   = iocs & ~iorw;
    assign buf_rd  = rd_en && (ioaddr == ADDR_BUF);
    assign stat_rd = rd_en && (ioaddr == ADDR_STAT);
    assign buf_wr  = wr_en && (ioaddr == ADDR_BUF);
    assign dbl_wr  = wr_en && (ioaddr == ADDR_DBL);
    assign dbh_wr  = wr_en && (ioaddr == ADDR_DBH);

    assign rda     = rda_q;
    assign tbr     = tbr_q;
    // Hand the held byte over as soon as the engine is idle; tbr rising blocks a repeat load
    assign tx_load = ~tbr_q & ~tx_busy;
    assign tx_byte = tx_hold_q;

    always_comb begin
        status             = '0;
        status[STAT_RDA]   = rda_q;
        status[STAT_TBR]   = tbr_q;
        status[STAT_RXOVR] = rx_ovr_q;
        status[STAT_TXOVR] = tx_ovr_q;
    end

    always_comb begin
        unique case (ioaddr)
            ADDR_BUF:  rdata = rx_buf_q;
            ADDR_STAT: rdata = status;
            ADDR_DBL:  rdata = div_q[7:0];
            default:   rdata = div_q[15:8];
        endcase
    end

    assign databus = rd_en ? rdata : 8'bz;

    always_comb begin
        rx_buf_d  = rx_buf_q;
        rda_d     = rda_q;
        rx_ovr_d  = rx_ovr_q;
        tx_hold_d = tx_hold_q;
        tbr_d     = tbr_q;
        tx_ovr_d  = tx_ovr_q;
        div_d     = div_q;

        // A byte landing during a buffer read replaces a byte that was just consumed
        if (rx_valid) begin
            rx_buf_d = rx_byte;
            rda_d    = 1'b1;
        end else if (buf_rd) begin
            rda_d = 1'b0;
        end

        if (rx_valid && rda_q && !buf_rd) begin
            rx_ovr_d = 1'b1;
        end else if (stat_rd) begin
            rx_ovr_d = 1'b0;
        end

        if (buf_wr && tbr_q) begin
            tx_hold_d = databus;
            tbr_d     = 1'b0;
        end else if (tx_load) begin
            tbr_d = 1'b1;
        end

        if (buf_wr && !tbr_q) begin
            tx_ovr_d = 1'b1;
        end else if (stat_rd) begin
            tx_ovr_d = 1'b0;
        end

        if (dbl_wr) div_d[7:0]  = databus;
        if (dbh_wr) div_d[15:8] = databus;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_buf_q  <= '0;
            rda_q     <= 1'b0;
            rx_ovr_q  <= 1'b0;
            tx_hold_q <= '0;
            tbr_q     <= 1'b1;
            tx_ovr_q  <= 1'b0;
            div_q     <= DEF_DIVISOR;
        end else begin
            rx_buf_q  <= rx_buf_d;
            rda_q     <= rda_d;
            rx_ovr_q  <= rx_ovr_d;
            tx_hold_q <= tx_hold_d;
            tbr_q     <= tbr_d;
            tx_ovr_q  <= tx_ovr_d;
            div_q     <= div_d;
        end
    end

    // The counter sees the post-write divisor so a DB write reloads with the new value
    spart_baud_gen #(
        .DIV_W       (DIV_W),
        .DEF_DIVISOR (DEF_DIVISOR)
    ) u_baud_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .divisor   (div_d),
        .reload    (dbl_wr | dbh_wr),
        .baud_tick (baud_tick)
    );

endmodule
